cordic_vec_pipe: RTL and testbench

CORDIC_VEC_PIPE -- requirements
Module: cordic_vec_pipe

---
 rtl/cordic_vec_pipe.sv | 160 ++++++++++++++++
 tb/tb_cordic_vec_pipe.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cordic_vec_pipe.sv
// Fully pipelined CORDIC vectoring unit: atan2(y_in, x_in) phase and magnitude, one sample per clock.
// Define CORDIC_GAIN_COMP_EN to add a register stage that removes the CORDIC gain from mag_out.
module cordic_vec_pipe #(
   parameter int WIDTH   = 16,
   parameter int STAGES  = 15,
   parameter int PHASE_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   x_in,
   input  logic [WIDTH-1:0]   y_in,
   output logic               out_valid,
   output logic [PHASE_W-1:0] phase_out,
   output logic [WIDTH+1:0]   mag_out
);
   localparam int  XW = WIDTH + 2;
   localparam real PI = 3.14159265358979323846;

   typedef logic [PHASE_W-1:0] ang_t;
   localparam ang_t QUARTER = {2'b01, {(PHASE_W-2){1'b0}}};

   function automatic ang_t atan_const(input int i);
      real a;
      a = $atan(2.0 ** (-i)) * (2.0 ** (PHASE_W - 1)) / PI;
      return ang_t'(longint'(a));
   endfunction

   ang_t ang [STAGES];
   for (genvar g = 0; g < STAGES; g++) begin : g_ang
      localparam ang_t A_G = atan_const(g);
      assign ang[g] = A_G;
   end

   logic signed [XW-1:0] x_ext, y_ext;
   logic signed [XW-1:0] x_q [STAGES+1];
   logic signed [XW-1:0] x_d [STAGES+1];
   logic signed [XW-1:0] y_q [STAGES];
   logic signed [XW-1:0] y_d [STAGES];
   ang_t                 z_q [STAGES+1];
   ang_t                 z_d [STAGES+1];
   logic [STAGES:0]      vld_q, vld_d, zro_q, zro_d;

   assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
   assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};

   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      z_d   = z_q;
      vld_d = {vld_q[STAGES-1:0], in_valid};
      zro_d = {zro_q[STAGES-1:0], (x_in == '0) && (y_in == '0)};
      // fold the left half-plane into the right so the micro-rotations can converge
      if (!x_ext[XW-1]) begin
         x_d[0] = x_ext;
         y_d[0] = y_ext;
         z_d[0] = '0;
      end else if (!y_ext[XW-1]) begin
         x_d[0] = y_ext;
         y_d[0] = -x_ext;
         z_d[0] = QUARTER;
      end else begin
         x_d[0] = -y_ext;
         y_d[0] = x_ext;
         z_d[0] = -QUARTER;
      end
      for (int i = 0; i < STAGES; i++) begin
         if (y_q[i][XW-1]) begin
            x_d[i+1] = x_q[i] - (y_q[i] >>> i);
            z_d[i+1] = z_q[i] - ang[i];
         end else begin
            x_d[i+1] = x_q[i] + (y_q[i] >>> i);
            z_d[i+1] = z_q[i] + ang[i];
         end
      end
      // the last stage's y is never consumed, so y stops one stage short
      for (int i = 0; i < STAGES - 1; i++) begin
         if (y_q[i][XW-1]) y_d[i+1] = y_q[i] + (x_q[i] >>> i);
         else              y_d[i+1] = y_q[i] - (x_q[i] >>> i);
      end
   end

   always_ff @(posedge clk) begin
      x_q   <= x_d;
      y_q   <= y_d;
      z_q   <= z_d;
      zro_q <= zro_d;
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
   end

   logic          fin_vld;
   ang_t          fin_ph;
   logic [XW-1:0] fin_mag;
   ang_t          ph_last;

   // a zero vector has no defined angle; report 0 rather than the sum of all micro-angles
   assign ph_last = zro_q[STAGES] ? '0 : z_q[STAGES];

`ifdef CORDIC_GAIN_COMP_EN
   localparam int            PW     = XW + 16;
   localparam logic [PW-1:0] K_GAIN = PW'(39797);
   localparam logic [PW-1:0] K_HALF = PW'(32768);

   logic          gc_vld_q, gc_vld_d;
   ang_t          gc_ph_q, gc_ph_d;
   logic [XW-1:0] gc_mag_q, gc_mag_d;

   always_comb begin
      gc_vld_d = vld_q[STAGES];
      gc_ph_d  = ph_last;
      gc_mag_d = XW'((PW'($unsigned(x_q[STAGES])) * K_GAIN + K_HALF) >> 16);
   end

   always_ff @(posedge clk) begin
      gc_ph_q  <= gc_ph_d;
      gc_mag_q <= gc_mag_d;
      if (rst) gc_vld_q <= 1'b0;
      else     gc_vld_q <= gc_vld_d;
   end

   assign fin_vld = gc_vld_q;
   assign fin_ph  = gc_ph_q;
   assign fin_mag = gc_mag_q;
`else
   assign fin_vld = vld_q[STAGES];
   assign fin_ph  = ph_last;
   assign fin_mag = x_q[STAGES];
`endif

   logic          out_valid_q, out_valid_d;
   ang_t          phase_out_q, phase_out_d;
   logic [XW-1:0] mag_out_q, mag_out_d;

   always_comb begin
      out_valid_d = fin_vld;
      phase_out_d = phase_out_q;
      mag_out_d   = mag_out_q;
      if (fin_vld) begin
         phase_out_d = fin_ph;
         mag_out_d   = fin_mag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         phase_out_q <= '0;
         mag_out_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         phase_out_q <= phase_out_d;
         mag_out_q   <= mag_out_d;
      end
   end

   assign out_valid = out_valid_q;
   assign phase_out = phase_out_q;
   assign mag_out   = mag_out_q;
endmodule

// File: tb/tb_cordic_vec_pipe.sv
// Directed self-checking bench for cordic_vec_pipe: single-sample latency/accuracy,
// valid-gap pattern with output hold, and mid-stream reset flush.
module tb_cordic_vec_pipe;
   localparam int WIDTH   = 16;
   localparam int STAGES  = 15;
   localparam int PHASE_W = 32;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int  LAT  = STAGES + 3;
   localparam real GAIN = 1.0;
`else
   localparam int  LAT  = STAGES + 2;
   localparam real GAIN = 1.646760258;
`endif
   localparam longint PH_TOL = 64'h0012_3457;

   logic               clk      = 1'b0;
   logic               rst      = 1'b1;
   logic               in_valid = 1'b0;
   logic [WIDTH-1:0]   x_in     = '0;
   logic [WIDTH-1:0]   y_in     = '0;
   logic               out_valid;
   logic [PHASE_W-1:0] phase_out;
   logic [WIDTH+1:0]   mag_out;

   int n_chk = 0;
   int n_err = 0;

   // vector table: inputs, true angle in degrees, true magnitude, magnitude tolerance
   logic signed [WIDTH-1:0] vx [7] = '{16'sd1000, 16'sd0, -16'sd1000, -16'sd707, 16'sh8000, 16'sd600, 16'sd0};
   logic signed [WIDTH-1:0] vy [7] = '{16'sd0, 16'sd1000, 16'sd0, -16'sd707, 16'sh8000, 16'sd800, 16'sd0};
   real vdeg [7] = '{0.0, 90.0, -180.0, -135.0, -135.0, 53.130102, 0.0};
   real vmag [7] = '{1000.0, 1000.0, 1000.0, 999.849, 46340.950, 1000.0, 0.0};
   int  vtol [7] = '{2, 2, 2, 4, 4, 2, 0};

   always #5 clk = ~clk;

   cordic_vec_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .PHASE_W(PHASE_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .x_in      (x_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .phase_out (phase_out),
      .mag_out   (mag_out)
   );

   task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
      longint d;
      n_chk++;
      d = obs - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   function automatic longint deg2ph(input real d);
      return longint'(d * 4294967296.0 / 360.0);
   endfunction

   function automatic longint mag_exp(input int k);
      return longint'(vmag[k] * GAIN);
   endfunction

   function automatic longint ph_obs();
      return longint'($signed(phase_out));
   endfunction

   task automatic check_vec(input string tag, input int k);
      check({tag, "_ph"}, ph_obs(), deg2ph(vdeg[k]), PH_TOL);
      check({tag, "_mag"}, longint'(mag_out), mag_exp(k), longint'(vtol[k]));
   endtask

   task automatic run_single(input int k);
      int n;
      @(negedge clk);
      x_in = vx[k];
      y_in = vy[k];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      x_in = 16'h1234;
      y_in = 16'hC321;
      n = 1;
      while (!out_valid && n < LAT + 10) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("lat%0d", k), n, LAT, 0);
      check_vec($sformatf("single%0d", k), k);
      @(negedge clk);
      check($sformatf("pulse%0d", k), out_valid, 0, 0);
      check_vec($sformatf("hold%0d", k), k);
   endtask

   task automatic run_pattern();
      int pv [5] = '{1, 0, 1, 1, 0};
      int pk [5] = '{0, 0, 1, 5, 5};
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         in_valid = pv[i][0];
         x_in = pv[i] != 0 ? vx[pk[i]] : -16'sd500;
         y_in = pv[i] != 0 ? vy[pk[i]] : -16'sd300;
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (LAT - 5) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("pat_vld%0d", i), out_valid, pv[i], 0);
         check_vec($sformatf("pat%0d", i), pk[i]);
         @(negedge clk);
      end
   endtask

   task automatic run_stream();
      int q_idx [$];
      int q_cyc [$];
      int n_out;
      int k;
      n_out = 0;
      for (int c = 0; c < 20 + LAT + 4; c++) begin
         @(negedge clk);
         if (c == 11) check("rst_flush", out_valid, 0, 0);
         if (out_valid) begin
            check("stale_out", longint'(q_idx.size() > 0), 1, 0);
            if (q_idx.size() > 0) begin
               k = q_idx.pop_front();
               check("stream_lat", c - q_cyc.pop_front(), LAT, 0);
               check_vec($sformatf("stream%0d", k), k);
               n_out++;
            end
         end
         rst      = (c == 10);
         in_valid = (c < 20);
         k        = c % 6;
         x_in     = vx[k];
         y_in     = vy[k];
         if (c < 20) begin
            if (rst) begin
               q_idx.delete();
               q_cyc.delete();
            end else begin
               q_idx.push_back(k);
               q_cyc.push_back(c);
            end
         end
      end
      rst = 1'b0;
      in_valid = 1'b0;
      check("stream_cnt", n_out, 9, 0);
   endtask

   initial begin
      // in_valid asserted during reset must be ignored
      in_valid = 1'b1;
      x_in = 16'd1000;
      repeat (3) @(negedge clk);
      check("rst_vld", out_valid, 0, 0);
      check("rst_ph", longint'(phase_out), 0, 0);
      check("rst_mag", longint'(mag_out), 0, 0);
      rst = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 7; k++) run_single(k);
      run_pattern();
      run_stream();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_chk, n_err);
      $fatal(1);
   end
endmodule
